// File: rtl/nios1_nios2_qsys_0_jtag_debug_pkg.sv
// Shared types and constants for the Nios II JTAG debug scan driver and its TAP-side peers.
package nios1_nios2_qsys_0_jtag_debug_pkg;

    localparam int IR_W           = 2;
    localparam int DEFAULT_DR_LEN = 38;

    // Virtual IR codes understood by the debug TAP
    localparam logic [IR_W-1:0] IR_MONITOR = 2'd0;
    localparam logic [IR_W-1:0] IR_TRACE   = 2'd1;
    localparam logic [IR_W-1:0] IR_BREAK   = 2'd2;
    localparam logic [IR_W-1:0] IR_DEBUG   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UIR,
        ST_CDR,
        ST_SDR,
        ST_UDR,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic uir;
        logic cdr;
        logic sdr;
        logic udr;
        logic rti;
        logic cmd_ready;
        logic rsp_valid;
    } ind_t;

    // Indicator outputs that belong to a state; registered together with the state itself
    function automatic ind_t state_ind(state_t s);
        ind_t ind;
        ind = '0;
        case (s)
            ST_IDLE: begin
                ind.rti       = 1'b1;
                ind.cmd_ready = 1'b1;
            end
            ST_UIR:  ind.uir       = 1'b1;
            ST_CDR:  ind.cdr       = 1'b1;
            ST_SDR:  ind.sdr       = 1'b1;
            ST_UDR:  ind.udr       = 1'b1;
            ST_DONE: ind.rsp_valid = 1'b1;
            default: ind = '0;
        endcase
        return ind;
    endfunction

endpackage

// File: rtl/nios1_nios2_qsys_0_jtag_debug_tck_gen.sv
// Scan clock divider: TCK_DIV clk cycles low then TCK_DIV high, with strobes on the cycle before each tck edge.
module nios1_nios2_qsys_0_jtag_debug_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tck,
    output logic tck_rise,
    output logic tck_fall
);

    localparam int               DIV_W    = 8;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_tck;
    logic             w_half_end;

    assign w_half_end = run && (r_div == DIV_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
            r_tck <= 1'b0;
        end else if (!run) begin
            r_div <= '0;
            r_tck <= 1'b0;
        end else if (w_half_end) begin
            r_div <= '0;
            r_tck <= ~r_tck;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Strobes are high in the cycle whose closing clk edge moves tck
    assign tck      = r_tck;
    assign tck_rise = w_half_end & ~r_tck;
    assign tck_fall = w_half_end &  r_tck;

endmodule

// File: rtl/nios1_nios2_qsys_0_jtag_debug_scan_driver.sv
// One virtual-JTAG UIR/CDR/SDR/UDR scan per accepted command, captured tdo returned as the response.
// Define NIOS1_JTAG_DRV_IR_CACHE_EN to skip the UIR phase when the requested IR matches the last one loaded.
module nios1_nios2_qsys_0_jtag_debug_scan_driver
    import nios1_nios2_qsys_0_jtag_debug_pkg::*;
#(
    parameter int TCK_DIV = 2,
    parameter int DR_LEN  = DEFAULT_DR_LEN
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [IR_W-1:0]   cmd_ir,
    input  logic [DR_LEN-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DR_LEN-1:0] rsp_data,
    output logic              tck,
    output logic              tdi,
    input  logic              tdo,
    output logic [IR_W-1:0]   ir_in,
    output logic              vs_uir,
    output logic              vs_cdr,
    output logic              vs_sdr,
    output logic              vs_udr,
    output logic              jtag_state_rti
);

    localparam int               CNT_W    = $clog2(DR_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DR_LEN - 1);

    state_t            r_state;
    ind_t              r_ind;
    logic [IR_W-1:0]   r_ir_in;
    logic [DR_LEN-1:0] r_dr;
    logic [DR_LEN-1:0] r_rsp_data;
    logic              r_tdi;
    logic [CNT_W-1:0]  r_bit_cnt;

    logic w_run;
    logic w_tck;
    logic w_tck_rise;
    logic w_tck_fall;
    logic w_ir_hit;

    assign w_run = (r_state != ST_IDLE) && (r_state != ST_DONE);

    nios1_nios2_qsys_0_jtag_debug_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (w_run),
        .tck      (w_tck),
        .tck_rise (w_tck_rise),
        .tck_fall (w_tck_fall)
    );

`ifdef NIOS1_JTAG_DRV_IR_CACHE_EN
    logic [IR_W-1:0] r_ir_cache;
    logic            r_ir_cache_vld;

    // The cache only learns from a UIR that ran to completion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir_cache     <= '0;
            r_ir_cache_vld <= 1'b0;
        end else if ((r_state == ST_UIR) && w_tck_fall) begin
            r_ir_cache     <= r_ir_in;
            r_ir_cache_vld <= 1'b1;
        end
    end

    assign w_ir_hit = r_ir_cache_vld && (cmd_ir == r_ir_cache);
`else
    assign w_ir_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_ind      <= state_ind(ST_IDLE);
            r_ir_in    <= IR_MONITOR;
            r_dr       <= '0;
            r_rsp_data <= '0;
            r_tdi      <= 1'b0;
            r_bit_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_dr <= cmd_data;
                        if (w_ir_hit) begin
                            r_state <= ST_CDR;
                            r_ind   <= state_ind(ST_CDR);
                        end else begin
                            r_ir_in <= cmd_ir;
                            r_state <= ST_UIR;
                            r_ind   <= state_ind(ST_UIR);
                        end
                    end
                end
                ST_UIR: begin
                    if (w_tck_fall) begin
                        r_state <= ST_CDR;
                        r_ind   <= state_ind(ST_CDR);
                    end
                end
                ST_CDR: begin
                    // Bit 0 goes out for the whole first SDR period
                    if (w_tck_fall) begin
                        r_state   <= ST_SDR;
                        r_ind     <= state_ind(ST_SDR);
                        r_tdi     <= r_dr[0];
                        r_dr      <= r_dr >> 1;
                        r_bit_cnt <= '0;
                    end
                end
                ST_SDR: begin
                    if (w_tck_rise) begin
                        r_rsp_data[r_bit_cnt] <= tdo;
                    end
                    if (w_tck_fall) begin
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state   <= ST_UDR;
                            r_ind     <= state_ind(ST_UDR);
                            r_tdi     <= 1'b0;
                            r_bit_cnt <= '0;
                        end else begin
                            r_tdi     <= r_dr[0];
                            r_dr      <= r_dr >> 1;
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_UDR: begin
                    if (w_tck_fall) begin
                        r_state <= ST_DONE;
                        r_ind   <= state_ind(ST_DONE);
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                        r_ind   <= state_ind(ST_IDLE);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ind   <= state_ind(ST_IDLE);
                end
            endcase
        end
    end

    assign cmd_ready      = r_ind.cmd_ready;
    assign rsp_valid      = r_ind.rsp_valid;
    assign rsp_data       = r_rsp_data;
    assign tck            = w_tck;
    assign tdi            = r_tdi;
    assign ir_in          = r_ir_in;
    assign vs_uir         = r_ind.uir;
    assign vs_cdr         = r_ind.cdr;
    assign vs_sdr         = r_ind.sdr;
    assign vs_udr         = r_ind.udr;
    assign jtag_state_rti = r_ind.rti;

endmodule

// File: tb/tb_nios1_nios2_qsys_0_jtag_debug_scan_driver.sv
// Bench for the JTAG debug scan driver: table-driven and random scans against a phase-arithmetic model.
module tb_nios1_nios2_qsys_0_jtag_debug_scan_driver;

    localparam int DRL = 38;
    localparam int TD  = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [1:0]     cmd_ir, ir_in;
    logic [DRL-1:0] cmd_data, rsp_data;
    logic           tck, tdi, tdo;
    logic           vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti;

    logic           d1_cmd_valid, d1_cmd_ready, d1_rsp_valid, d1_rsp_ready;
    logic [1:0]     d1_cmd_ir, d1_ir_in;
    logic [DRL-1:0] d1_cmd_data, d1_rsp_data;
    logic           d1_tck, d1_tdi, d1_tdo;
    logic           d1_vs_uir, d1_vs_cdr, d1_vs_sdr, d1_vs_udr, d1_rti;

    int n_assert = 0;
    int n_fail   = 0;

    bit         m_cache_vld = 1'b0;
    logic [1:0] m_cache_ir  = 2'b00;

    typedef struct {
        logic [1:0]     ir;
        logic [DRL-1:0] data;
        int             mode;     // 0: tdo=tdi loopback, 1: tdo=1, 2: tdo from pattern
        logic [DRL-1:0] pat;
        logic [DRL-1:0] exp_rsp;
        int             hold;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    nios1_nios2_qsys_0_jtag_debug_scan_driver #(.TCK_DIV(TD), .DR_LEN(DRL)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in),
        .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
        .jtag_state_rti(jtag_state_rti)
    );

    nios1_nios2_qsys_0_jtag_debug_scan_driver #(.TCK_DIV(1), .DR_LEN(DRL)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(d1_cmd_valid), .cmd_ready(d1_cmd_ready), .cmd_ir(d1_cmd_ir), .cmd_data(d1_cmd_data),
        .rsp_valid(d1_rsp_valid), .rsp_ready(d1_rsp_ready), .rsp_data(d1_rsp_data),
        .tck(d1_tck), .tdi(d1_tdi), .tdo(d1_tdo), .ir_in(d1_ir_in),
        .vs_uir(d1_vs_uir), .vs_cdr(d1_vs_cdr), .vs_sdr(d1_vs_sdr), .vs_udr(d1_vs_udr),
        .jtag_state_rti(d1_rti)
    );

    task automatic check(input string what, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", what, act, exp);
        end
    endtask

    // A command needs the UIR phase unless the cache is enabled and already holds this IR
    function automatic bit model_uir(input logic [1:0] ir);
`ifdef NIOS1_JTAG_DRV_IR_CACHE_EN
        return !(m_cache_vld && (m_cache_ir == ir));
`else
        return 1'b1;
`endif
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ctrl"},
              64'({tck, tdi, ir_in, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti, cmd_ready, rsp_valid}),
              64'(11'b000_0000_0110));
        check({tag, ".rsp_data"}, 64'(rsp_data), 64'(0));
    endtask

    task automatic run_scan(input logic [1:0] ir, input logic [DRL-1:0] data, input int mode,
                            input logic [DRL-1:0] pat, input logic [DRL-1:0] exp_rsp,
                            input int hold, input string name);
        bit       exp_uir;
        int       exp_lat, lat, off, p, rises;
        int       bad_tck, bad_vs, bad_tdi, bad_busy, bad_ir, bad_hold;
        logic     prev_tck, exp_tdi;
        logic [3:0] exp_vs;
        exp_uir = model_uir(ir);
        exp_lat = (DRL + (exp_uir ? 3 : 2)) * 2 * TD;
        off     = exp_uir ? 0 : 1;
        bad_tck = 0; bad_vs = 0; bad_tdi = 0; bad_busy = 0; bad_ir = 0; bad_hold = 0;
        rises = 0; prev_tck = 1'b0;
        tdo = 1'b0;

        @(negedge clk);
        check({name, ".ready_idle"}, 64'(cmd_ready), 64'(1));
        cmd_ir = ir; cmd_data = data; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        // Keep offering junk while busy: it must be neither accepted nor used
        cmd_ir   = 2'($urandom);
        cmd_data = DRL'({$urandom, $urandom});

        lat = 0;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1 || lat > 2000) break;
            if (tck && !prev_tck && vs_sdr) rises++;
            prev_tck = tck;
            tdo = (mode == 0) ? tdi : (mode == 1) ? 1'b1 : ((rises < DRL) ? pat[rises] : 1'b0);
            p = lat / (2 * TD) + off;
            exp_vs  = (p == 0) ? 4'b1000 : (p == 1) ? 4'b0100 :
                      (p <= DRL + 1) ? 4'b0010 : (p == DRL + 2) ? 4'b0001 : 4'b0000;
            exp_tdi = (p >= 2 && p <= DRL + 1) ? data[p - 2] : 1'b0;
            if (tck !== 1'((lat / TD) % 2)) bad_tck++;
            if ({vs_uir, vs_cdr, vs_sdr, vs_udr} !== exp_vs) bad_vs++;
            if (!$onehot0({vs_uir, vs_cdr, vs_sdr, vs_udr})) bad_vs++;
            if (tdi !== exp_tdi) bad_tdi++;
            if (cmd_ready !== 1'b0 || jtag_state_rti !== 1'b0) bad_busy++;
            if (p == 0 && ir_in !== ir) bad_ir++;
            lat++;
        end
        cmd_valid = 1'b0;

        check({name, ".latency"},  64'(lat), 64'(exp_lat));
        check({name, ".rsp_data"}, 64'(rsp_data), 64'(exp_rsp));
        check({name, ".tck_shape"}, 64'(bad_tck), 64'(0));
        check({name, ".vs_phase"},  64'(bad_vs), 64'(0));
        check({name, ".tdi_value"}, 64'(bad_tdi), 64'(0));
        check({name, ".busy_ready"}, 64'(bad_busy), 64'(0));
        check({name, ".ir_in_uir"}, 64'(bad_ir), 64'(0));
        check({name, ".sdr_rises"}, 64'(rises), 64'(DRL));
        check({name, ".done_pins"}, 64'({tck, tdi, cmd_ready, ir_in}), 64'({3'b000, ir}));

        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'($urandom);
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== exp_rsp || cmd_ready !== 1'b0) bad_hold++;
        end
        cmd_valid = 1'b0;
        check({name, ".done_hold"}, 64'(bad_hold), 64'(0));

        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check({name, ".back_idle"}, 64'({cmd_ready, rsp_valid, jtag_state_rti}), 64'(3'b101));

        if (exp_uir) begin
            m_cache_vld = 1'b1;
            m_cache_ir  = ir;
        end
        $display("scan %s ir=%b data=%h rsp=%h latency=%0d uir=%0d", name, ir, data, rsp_data, lat, exp_uir);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int             lat, rises, bad_tck, bad_tdi;
        logic           prev_tck;
        logic [DRL-1:0] d, pt, ex;
        int             md;

        vecs[0] = '{2'b01, 38'h15_5555_5555, 0, 38'h0,            38'h15_5555_5555, 0};
        vecs[1] = '{2'b10, 38'h2A_AAAA_AAAA, 2, 38'h00_FFFF_0000, 38'h00_FFFF_0000, 2};
        vecs[2] = '{2'b10, 38'h3F_FFFF_FFFF, 0, 38'h0,            38'h3F_FFFF_FFFF, 0};
        vecs[3] = '{2'b11, 38'h0,            1, 38'h0,            38'h3F_FFFF_FFFF, 50};
        vecs[4] = '{2'b11, 38'h20_0000_0001, 0, 38'h0,            38'h20_0000_0001, 1};
        vecs[5] = '{2'b00, 38'h12_3456_789A, 2, 38'h25_A5A5_5A5A, 38'h25_A5A5_5A5A, 0};

        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_ir = 2'b00; cmd_data = '0; rsp_ready = 1'b0; tdo = 1'b0;
        d1_cmd_valid = 1'b0; d1_cmd_ir = 2'b00; d1_cmd_data = '0; d1_rsp_ready = 1'b0; d1_tdo = 1'b1;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_release");

        for (int i = 0; i < 6; i++)
            run_scan(vecs[i].ir, vecs[i].data, vecs[i].mode, vecs[i].pat, vecs[i].exp_rsp,
                     vecs[i].hold, $sformatf("vec%0d", i));

        for (int i = 0; i < 8; i++) begin
            d  = DRL'({$urandom, $urandom});
            pt = DRL'({$urandom, $urandom});
            md = int'($urandom_range(0, 2));
            ex = (md == 0) ? d : (md == 1) ? {DRL{1'b1}} : pt;
            run_scan(2'($urandom_range(0, 3)), d, md, pt, ex, int'($urandom_range(0, 3)),
                     $sformatf("rand%0d", i));
        end

        // Abort a scan with reset while bit 20 is being shifted
        @(negedge clk);
        cmd_ir = 2'b01; cmd_data = 38'h0A_5A5A_A5A5; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        rises = 0; prev_tck = 1'b0; lat = 0;
        while (rises < 21 && lat < 1000) begin
            @(negedge clk);
            if (tck && !prev_tck && vs_sdr) rises++;
            prev_tck = tck;
            tdo = tdi;
            lat++;
        end
        check("abort.reached_bit20", 64'({vs_sdr, 8'(rises)}), 64'({1'b1, 8'd21}));
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("abort.async");
        m_cache_vld = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("abort.held");
        reset_n = 1'b1;
        $display("scan abort ir=01 reset during sdr bit 20");
        run_scan(2'b01, 38'h15_5555_5555, 0, 38'h0, 38'h15_5555_5555, 0, "post_reset");

        // TCK_DIV=1 instance with tdo tied high and all-zero data
        @(negedge clk);
        check("div1.ready_idle", 64'(d1_cmd_ready), 64'(1));
        d1_cmd_ir = 2'b11; d1_cmd_data = '0; d1_cmd_valid = 1'b1;
        @(posedge clk);
        #1 d1_cmd_valid = 1'b0;
        lat = 0; bad_tck = 0; bad_tdi = 0;
        forever begin
            @(negedge clk);
            if (d1_rsp_valid === 1'b1 || lat > 1000) break;
            if (d1_tck !== 1'(lat % 2)) bad_tck++;
            if (d1_tdi !== 1'b0) bad_tdi++;
            if (!$onehot0({d1_vs_uir, d1_vs_cdr, d1_vs_sdr, d1_vs_udr})) bad_tdi++;
            lat++;
        end
        check("div1.latency",  64'(lat), 64'((DRL + 3) * 2));
        check("div1.rsp_data", 64'(d1_rsp_data), 64'(38'h3F_FFFF_FFFF));
        check("div1.tck_period2", 64'(bad_tck), 64'(0));
        check("div1.tdi_zero", 64'(bad_tdi), 64'(0));
        check("div1.done_tck", 64'({d1_tck, d1_tdi}), 64'(0));
        d1_rsp_ready = 1'b1;
        @(posedge clk);
        #1 d1_rsp_ready = 1'b0;
        @(negedge clk);
        check("div1.back_idle", 64'({d1_cmd_ready, d1_rsp_valid, d1_rti}), 64'(3'b101));
        $display("scan div1 ir=11 data=0 rsp=%h latency=%0d", d1_rsp_data, lat);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/nios1_nios2_qsys_0_jtag_debug_scan_driver.md
NIOS1_NIOS2_QSYS_0_JTAG_DEBUG_SCAN_DRIVER -- requirements
Module: nios1_nios2_qsys_0_jtag_debug_scan_driver

Interface
REQ-001 Parameter TCK_DIV, default 2: clk cycles per tck half-period; legal range 1..255.
REQ-002 Parameter DR_LEN, default 38: data-register scan length in bits.
REQ-003 Port clk  input  1: the single clock; all state is clocked on its rising edge.
REQ-004 Port reset_n  input  1: reset, asynchronous and active-low.
REQ-005 Port cmd_valid  input  1: a scan command is offered.
REQ-006 Port cmd_ready  output  1: the driver accepts the command this cycle.
REQ-007 Port cmd_ir  input  2: virtual IR value for the scan.
REQ-008 Port cmd_data  input  DR_LEN: DR value to shift out; LSB is shifted first.
REQ-009 Port rsp_valid  output  1: captured DR data is available.
REQ-010 Port rsp_ready  input  1: the consumer takes the response.
REQ-011 Port rsp_data  output  DR_LEN: captured tdo bits; bit 0 is the first bit captured.
REQ-012 Port tck / tdi  output  1 each: scan clock and scan data toward the debug TAP.
REQ-013 Port tdo  input  1: scan data from the debug TAP.
REQ-014 Port ir_in  output  2: virtual IR value presented to the TAP.
REQ-015 Port vs_uir / vs_cdr / vs_sdr / vs_udr / jtag_state_rti  output  1 each: virtual-state indicators.

Function
REQ-016 tck SHALL be a square wave of TCK_DIV clk cycles low followed by TCK_DIV clk cycles high; it SHALL run only when the state is not IDLE or DONE, and SHALL be 0 otherwise.
REQ-017 States SHALL be IDLE, UIR, CDR, SDR, UDR and DONE; each non-IDLE/DONE state SHALL last a whole number of tck periods.
REQ-018 State changes and tdi updates SHALL occur only on the tck falling edge (the end of the high half).
REQ-019 tdo SHALL be sampled on the tck rising edge.
REQ-020 IDLE: cmd_ready=1 and jtag_state_rti=1; a cycle with cmd_valid&cmd_ready SHALL latch cmd_ir and cmd_data and enter UIR.
REQ-021 UIR SHALL last 1 tck period with ir_in=cmd_ir and vs_uir=1; it SHALL then go to CDR.
REQ-022 CDR SHALL last 1 period with vs_cdr=1, then go to SDR.
REQ-023 SDR SHALL last exactly DR_LEN periods with vs_sdr=1.
- tdi SHALL carry data bit k during period k.
- The tdo sample in period k SHALL go to rsp_data[k].
- The bit counter SHALL be ceil(log2(DR_LEN+1)) bits wide and SHALL leave SDR when it reaches DR_LEN-1; no wrap is permitted.
REQ-024 UDR SHALL last 1 period with vs_udr=1, then go to DONE.
REQ-025 DONE: rsp_valid=1, rsp_data stable and cmd_ready=0; rsp_valid&rsp_ready SHALL return the block to IDLE on the next cycle.
REQ-026 If cmd_valid is held while the block is busy, cmd_ready SHALL stay 0 and the command SHALL not be sampled.
REQ-027 ir_in SHALL hold its last value outside UIR; each vs_* output SHALL be asserted for its whole state only.
REQ-028 Latency from the accept cycle to rsp_valid=1 SHALL be (DR_LEN+3)·2·TCK_DIV clk cycles with an IR phase, and (DR_LEN+2)·2·TCK_DIV cycles with the IR phase skipped (REQ-033).
REQ-029 tdi SHALL be 0 whenever the state is not SDR.

Reset
REQ-030 While reset_n=0, asynchronously:
- state=IDLE;
- tck=0, tdi=0, ir_in=0;
- all vs_*=0, jtag_state_rti=1;
- cmd_ready=1, rsp_valid=0, rsp_data=0;
- the tck divider and bit counter cleared;
- the IR cache invalidated.
REQ-031 Reset asserted mid-scan SHALL abort the scan without a response; the first command after release SHALL perform a full UIR phase.

Configuration
REQ-032 The macro NIOS1_JTAG_DRV_IR_CACHE_EN SHALL select IR caching.
REQ-033 With the macro defined: if cmd_ir equals the IR of the last completed UIR and the cache is valid, IDLE SHALL go directly to CDR, skipping UIR; the cache SHALL become valid after any UIR.
REQ-034 Without the macro: every command SHALL execute UIR, and no cache register SHALL exist.

Structure
REQ-035 Package nios1_nios2_qsys_0_jtag_debug_pkg SHALL hold:
- the state enum;
- IR_W=2 and default DR_LEN=38;
- named IR codes (0..3) shared with the TAP side.
REQ-036 Sub-module nios1_nios2_qsys_0_jtag_debug_tck_gen SHALL hold the divider and produce tck plus single-cycle rise and fall strobes; run=0 SHALL force tck=0 and clear the divider.

Verification
REQ-037 With TCK_DIV=2, accept ir=2'b01, data=38'h15_5555_5555 and a tdo loopback of tdi: rsp_valid SHALL rise 164 clk cycles after the accept, with rsp_data=38'h15_5555_5555.
REQ-038 With the macro defined, two consecutive commands with ir=2'b10: the second SHALL have no vs_uir pulse and rsp_valid 160 cycles after its accept; changing ir to 2'b11 SHALL restore the UIR phase.
REQ-039 With rsp_ready held at 0 for 50 cycles in DONE: rsp_valid and rsp_data SHALL stay stable, and cmd_valid pulses in this window SHALL not be accepted.
REQ-040 reset_n pulsed low during SDR bit 20: all outputs SHALL reach reset values the same cycle; the next command SHALL show a vs_uir pulse and a correct 164-cycle response.
REQ-041 With tdo tied to 1, data=0 and TCK_DIV=1: tdi SHALL stay 0, rsp_data SHALL equal 38'h3F_FFFF_FFFF, and tck SHALL have period 2 clk cycles during the scan.
REQ-042 Checker: vs_cdr, vs_sdr, vs_udr and vs_uir SHALL be one-hot-or-zero on every cycle, and the number of vs_sdr tck rising edges SHALL equal 38.
